apb4_master: RTL and testbench
==============================

Name: apb4_master

Overview:
- APB4 initiator (requester) that converts a simple valid/ready request/response channel into single APB4 transfers.
- Used by CPU-side bridges and DMA/test harnesses to drive the APB4 peripherals (CLINT, timers, GPIO) on the peripheral bus.
- Issues one transfer at a time; no pipelining.
- Supports wait states, slave errors, and an optional PREADY timeout.

Parameters:
- ADDR_WIDTH, 32, width of req_addr_i/paddr_o.
- DATA_WIDTH, 32, width of the data buses; must be 8, 16 or 32.
- TIMEOUT, 255, maximum ACCESS cycles with pready_i low before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  bus clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&&ready.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_write_i  in  1  1=write, 0=read.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_strb_i  in  DATA_WIDTH/8  write byte strobes.
- req_prot_i  in  3  protection attributes.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&&ready.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_err_o  out  1  pslverr_i captured, or timeout.
- rsp_timeout_o  out  1  transfer aborted by timeout.
- paddr_o  out  ADDR_WIDTH  APB address.
- pprot_o  out  3  APB protection.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  DATA_WIDTH  APB write data.
- pstrb_o  out  DATA_WIDTH/8  APB strobes.
- pready_i  in  1  APB ready.
- prdata_i  in  DATA_WIDTH  APB read data.
- pslverr_i  in  1  APB error.

Behaviour:
- Reset: state IDLE; every output, counter and latched field is 0. req_ready_o rises in the first cycle after rst_i deasserts.
- States and transitions:
  - IDLE: req_ready_o=1. On req_valid_i, latch addr/write/wdata/strb/prot, then go to SETUP.
  - SETUP: psel_o=1, penable_o=0. Next cycle goes to ACCESS unconditionally.
  - ACCESS: psel_o=1, penable_o=1.
    - pready_i=1: capture prdata_i (reads only; writes give 0) and pslverr_i; go to RESP.
    - pready_i=0: stay in ACCESS and increment the wait counter.
  - RESP: rsp_valid_o=1 with the response fields stable; hold until rsp_ready_i, then go to IDLE.
- Handshake outputs: req_ready_o=1 only in IDLE; psel_o/penable_o=0 in IDLE and RESP. All are registered or decoded from state only, with no combinational path from any input.
- APB control signals:
  - paddr_o/pwrite_o/pprot_o/pwdata_o/pstrb_o are registered at accept and held stable through SETUP and ACCESS.
  - They keep their last value in IDLE/RESP.
  - pstrb_o is forced to 0 for reads; pwdata_o is forced to 0 for reads.
- Latency: accept at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2. With zero wait states, rsp_valid_o asserts in cycle 3. Minimum issue interval is 4 cycles (IDLE bubble after each response).
- Timeout (TIMEOUT>0):
  - The counter clears on entry to ACCESS and increments per ACCESS cycle with pready_i=0.
  - When the counter reaches TIMEOUT with pready_i still 0, next state is RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0; psel_o/penable_o drop.
  - If pready_i=1 in the same cycle the counter would hit TIMEOUT, the pready_i completion wins and is a normal response.
  - Counter width is clog2(TIMEOUT+1); it never wraps.
- TIMEOUT=0: waits indefinitely; rsp_timeout_o stays 0.
- req_valid_i is ignored outside IDLE. req_* may change freely once accepted.
- rsp_ready_i is ignored outside RESP.
- rst_i mid-transfer: psel_o/penable_o/rsp_valid_o drop asynchronously and the transfer is lost.
- rsp_err_o = pslverr_i sampled with pready_i, OR timeout.

Decomposition:
- Package apb4_master_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - the request struct (addr, write, wdata, strb, prot);
  - the response struct (rdata, err, timeout).
- The package is parameterised through localparams matching the defaults.
- One natural sub-module, apb4_master_tmo: a saturating wait counter with clear/enable inputs and an expired output. The FSM stays in the top module.

Test Plan:
- Write, addr 0x0C, wdata 0xDEADBEEF, strb 0xF, pready_i tied 1 → psel_o in cycles 1-2, penable_o in cycle 2, paddr_o=0x0C, pwrite_o=1; rsp_valid_o in cycle 3, rsp_err_o=0, rsp_rdata_o=0.
- Read, addr 0x04, slave returns 0x12345678 after 3 wait states → penable_o high 4 cycles; rsp_rdata_o=0x12345678; pstrb_o=0 throughout.
- Read with pslverr_i=1 and pready_i=1 → rsp_err_o=1, rsp_timeout_o=0.
- TIMEOUT=4, pready_i held 0 → abort after 4 ACCESS wait cycles; rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0, psel_o=0 in RESP. Also pready_i=1 on the 4th wait cycle → normal completion.
- Backpressure: rsp_ready_i low for 5 cycles with req_valid_i held high → rsp_valid_o held, fields stable, req_ready_o=0. The next transfer's SETUP begins 2 cycles after the response handshake.
- rst_i pulsed during ACCESS → psel_o/penable_o=0 immediately, no response issued, req_ready_o=1 the cycle after release.

Source files
------------

// File: rtl/apb4_master_pkg.sv
// Shared types and default widths for the APB4 initiator.
// The request/response structs are sized for the default (widest) configuration.
package apb4_master_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned STRB_W      = DATA_W / 8;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    logic [2:0]        prot;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              timeout;
  } rsp_t;

endpackage

// File: rtl/apb4_master_tmo.sv
// Saturating ACCESS wait counter; expired flags the wait cycle that reaches TIMEOUT.
// TIMEOUT=0 removes the counter entirely and the transfer may wait forever.
module apb4_master_tmo #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    logic unused;
    assign unused  = ^{clk_i, rst_i, clear, enable};
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] count;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        count <= '0;
      end else if (clear) begin
        count <= '0;
      end else if (enable && (count != CW'(TIMEOUT))) begin
        count <= count + 1'b1;
      end
    end

    // Combinational so the FSM can leave ACCESS on the very cycle the count would hit TIMEOUT.
    assign expired = enable && (count == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/apb4_master.sv
// APB4 initiator: turns a valid/ready request into one APB4 transfer and returns
// a valid/ready response. One transfer in flight, no pipelining.
//
//   state  | meaning
//   IDLE   | waiting for a request, req_ready_o high
//   SETUP  | psel high, penable low, one cycle
//   ACCESS | psel and penable high until pready or timeout
//   RESP   | response presented until rsp_ready_i
module apb4_master
  import apb4_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  state_t state_q, state_d;
  req_t   req_q;
  rsp_t   rsp_q;
  logic   ready_q;
  logic   accept, complete, abort, expired;

  apb4_master_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (state_q == SETUP),
    .enable  ((state_q == ACCESS) && !pready_i),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: if (req_valid_i && ready_q) begin
        accept  = 1'b1;
        state_d = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          complete = 1'b1;
          state_d  = RESP;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready is a flop so it stays low through reset and rises one cycle after release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      req_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      if (accept) begin
        req_q.addr  <= ADDR_W'(req_addr_i);
        req_q.write <= req_write_i;
        req_q.wdata <= req_write_i ? DATA_W'(req_wdata_i) : '0;
        req_q.strb  <= req_write_i ? STRB_W'(req_strb_i) : '0;
        req_q.prot  <= req_prot_i;
      end
      if (complete) begin
        rsp_q.rdata   <= req_q.write ? '0 : DATA_W'(prdata_i);
        rsp_q.err     <= pslverr_i;
        rsp_q.timeout <= 1'b0;
      end else if (abort) begin
        rsp_q.rdata   <= '0;
        rsp_q.err     <= 1'b1;
        rsp_q.timeout <= 1'b1;
      end
    end
  end

  assign req_ready_o   = ready_q;
  assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o     = (state_q == ACCESS);
  assign rsp_valid_o   = (state_q == RESP);
  assign paddr_o       = req_q.addr[ADDR_WIDTH-1:0];
  assign pwrite_o      = req_q.write;
  assign pwdata_o      = req_q.wdata[DATA_WIDTH-1:0];
  assign pstrb_o       = req_q.strb[DATA_WIDTH/8-1:0];
  assign pprot_o       = req_q.prot;
  assign rsp_rdata_o   = rsp_q.rdata[DATA_WIDTH-1:0];
  assign rsp_err_o     = rsp_q.err;
  assign rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_apb4_master.sv
// Self-checking bench for apb4_master with TIMEOUT=4: directed and random transfers
// against a transfer-level model of latency, wait states, errors and timeout.
module tb_apb4_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic          req_write_i = 1'b0;
  logic [DW-1:0] req_wdata_i = '0;
  logic [SW-1:0] req_strb_i = '0;
  logic [2:0]    req_prot_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;
  logic [AW-1:0] paddr_o;
  logic [2:0]    pprot_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [DW-1:0] pwdata_o;
  logic [SW-1:0] pstrb_o;
  logic          pready_i = 1'b0;
  logic [DW-1:0] prdata_i = '0;
  logic          pslverr_i = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  int            slv_waits = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic          slv_err   = 1'b0;
  int            acc_k     = 0;

  apb4_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
    .req_strb_i(req_strb_i), .req_prot_i(req_prot_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  // Slave: inserts slv_waits wait states, then completes; noise outside ACCESS.
  always @(negedge clk_i) begin
    if (psel_o && penable_o) begin
      acc_k     = acc_k + 1;
      pready_i  = (acc_k == slv_waits + 1);
      prdata_i  = pready_i ? slv_rdata : DW'($urandom);
      pslverr_i = pready_i ? slv_err : 1'b0;
    end else begin
      acc_k     = 0;
      pready_i  = 1'($urandom_range(0, 1));
      prdata_i  = DW'($urandom);
      pslverr_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the DUT in IDLE and req_ready_o already high.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [SW-1:0] strb, input logic [2:0] prot, input int waits,
                      input logic serr, input logic [DW-1:0] rdata, input int bp,
                      input bit hold_valid);
    bit            tmo;
    int            acc_exp, acc_seen, cyc;
    logic [DW-1:0] exp_rdata, exp_pwdata;
    logic [SW-1:0] exp_pstrb;
    logic          exp_err;
    tmo        = (waits >= TMO);
    acc_exp    = tmo ? TMO : waits + 1;
    exp_rdata  = (wr || tmo) ? '0 : rdata;
    exp_err    = tmo ? 1'b1 : serr;
    exp_pwdata = wr ? wdata : '0;
    exp_pstrb  = wr ? strb : '0;
    slv_waits  = waits;
    slv_rdata  = rdata;
    slv_err    = serr;

    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_strb_i  = strb;
    req_prot_i  = prot;
    chk("idle_req_ready", req_ready_o, 1);
    chk("idle_psel", psel_o, 0);
    @(posedge clk_i); #1;
    req_addr_i  = AW'($urandom);
    req_wdata_i = DW'($urandom);
    req_write_i = 1'($urandom_range(0, 1));
    req_strb_i  = SW'($urandom);
    req_prot_i  = 3'($urandom);
    req_valid_i = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
    chk("setup_psel", psel_o, 1);
    chk("setup_penable", penable_o, 0);
    chk("busy_req_ready", req_ready_o, 0);

    cyc = 1;
    acc_seen = 0;
    while (!rsp_valid_o && cyc < 40) begin
      if (psel_o) begin
        chk("paddr", paddr_o, addr);
        chk("pwrite", pwrite_o, wr);
        chk("pprot", pprot_o, prot);
        chk("pwdata", pwdata_o, exp_pwdata);
        chk("pstrb", pstrb_o, exp_pstrb);
      end
      if (penable_o) acc_seen++;
      @(posedge clk_i); #1;
      cyc++;
      req_valid_i = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
      rsp_ready_i = 1'($urandom_range(0, 1));
    end
    chk("rsp_latency", cyc, 2 + acc_exp);
    chk("penable_cycles", acc_seen, acc_exp);
    chk("resp_psel", psel_o, 0);
    chk("resp_penable", penable_o, 0);
    chk("resp_paddr_held", paddr_o, addr);
    chk("rsp_rdata", rsp_rdata_o, exp_rdata);
    chk("rsp_err", rsp_err_o, exp_err);
    chk("rsp_timeout", rsp_timeout_o, tmo);

    for (int i = 0; i < bp; i++) begin
      rsp_ready_i = 1'b0;
      @(posedge clk_i); #1;
      chk("bp_rsp_valid", rsp_valid_o, 1);
      chk("bp_rsp_rdata", rsp_rdata_o, exp_rdata);
      chk("bp_rsp_err", rsp_err_o, exp_err);
      chk("bp_req_ready", req_ready_o, 0);
      chk("bp_psel", psel_o, 0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    chk("post_rsp_valid", rsp_valid_o, 0);
    chk("post_req_ready", req_ready_o, 1);
  endtask

  initial begin
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_pwdata", pwdata_o, 0);
    chk("rst_pstrb", pstrb_o, 0);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rel_req_ready_low", req_ready_o, 0);
    @(posedge clk_i); #1;
    chk("rel_req_ready_high", req_ready_o, 1);

    // Directed: plain write, 3-wait read, slave error, timeouts, near-timeout.
    xfer(1'b1, 32'h0C, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 32'hAAAA5555, 0, 1'b0);
    xfer(1'b0, 32'h04, 32'hFFFFFFFF, 4'hF, 3'd2, 3, 1'b0, 32'h12345678, 0, 1'b0);
    xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'd1, 0, 1'b1, 32'hCAFEF00D, 0, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'd0, 10, 1'b0, 32'h11112222, 0, 1'b0);
    xfer(1'b1, 32'h14, 32'h01020304, 4'h3, 3'd7, 4, 1'b0, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h18, 32'h0, 4'h0, 3'd0, 3, 1'b1, 32'h55AA55AA, 0, 1'b0);
    // Backpressure with request held, then an immediate follow-on transfer.
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'd3, 1, 1'b0, 32'hBEEF0001, 5, 1'b1);
    xfer(1'b1, 32'h24, 32'h87654321, 4'h5, 3'd4, 0, 1'b0, 32'h0, 0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      xfer(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), SW'($urandom),
           3'($urandom), $urandom_range(0, 6), 1'($urandom_range(0, 1)), DW'($urandom),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset during ACCESS: everything drops at once and no response follows.
    slv_waits   = 10;
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 32'h30;
    req_wdata_i = 32'h13572468;
    req_strb_i  = 4'hF;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("pre_rst_penable", penable_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_psel", psel_o, 0);
    chk("midrst_penable", penable_o, 0);
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    chk("midrst_paddr", paddr_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("midrst_req_ready", req_ready_o, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      chk("midrst_no_rsp", rsp_valid_o, 0);
      chk("midrst_no_psel", psel_o, 0);
    end

    xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'd5, 2, 1'b0, 32'h0BADCAFE, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
